// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared pipeline definitions: register address width, hazard FSM states,
// and the NOP/bubble encodings that the pipeline registers load on a flush.
package pipe_pkg;

    localparam int unsigned REG_AW = 3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hazard_state_e;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter: increments on inc and holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Decode-stage hazard controller: load-use stall, branch squash, memory freeze,
// plus saturating stall/flush counters and a sticky memory-timeout flag.
module hazard_ctrl_unit
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW       = pipe_pkg::REG_AW,
    parameter int unsigned MAX_MEM_WAIT = 15,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] Rsrc1_id,
    input  logic [REG_AW-1:0] Rsrc2_id,
    input  logic              use_src1_id,
    input  logic              use_src2_id,
    input  logic [REG_AW-1:0] Rdst_ex,
    input  logic              MemRead_ex,
    input  logic              branch_ex,
    input  logic              mem_busy,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_write,
    output logic              idex_flush,
    output logic              exmem_write,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic              mem_timeout
);

    localparam logic [7:0] MAX_WAIT = 8'(MAX_MEM_WAIT);

    hazard_state_e state_q, state_d;
    logic [7:0]    wait_cnt_q, wait_cnt_d;
    logic          mem_timeout_q, mem_timeout_d;

    logic load_use;
    logic load_use_act;
    logic stall_inc;
    logic flush_inc;
    logic pc_write_c, ifid_write_c, ifid_flush_c, idex_flush_c, exmem_write_c;

    assign load_use = MemRead_ex &
                      ((use_src1_id & (Rsrc1_id == Rdst_ex)) |
                       (use_src2_id & (Rsrc2_id == Rdst_ex)));

    // The cycle after a stall EX holds the bubble, so the old match is stale.
    assign load_use_act = load_use & (state_q != LD_STALL);

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        pc_write_c    = 1'b1;
        ifid_write_c  = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_flush_c  = 1'b0;
        exmem_write_c = 1'b1;

        if (mem_busy) begin
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            exmem_write_c = 1'b0;
            state_d       = MEM_WAIT;
            if (wait_cnt_q != MAX_WAIT) begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
            if (wait_cnt_d == MAX_WAIT) begin
                mem_timeout_d = 1'b1;
            end
        end else begin
            wait_cnt_d = '0;
            state_d    = RUN;
            if (branch_ex) begin
                ifid_flush_c = 1'b1;
                idex_flush_c = 1'b1;
                flush_inc    = 1'b1;
            end else if (load_use_act) begin
                pc_write_c   = 1'b0;
                ifid_write_c = 1'b0;
                idex_flush_c = 1'b1;
                stall_inc    = 1'b1;
                state_d      = LD_STALL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

    // Enables are forced off combinationally while reset is asserted.
    assign pc_write    = rst_n & pc_write_c;
    assign ifid_write  = rst_n & ifid_write_c;
    assign ifid_flush  = rst_n & ifid_flush_c;
    assign idex_write  = rst_n & exmem_write_c;
    assign idex_flush  = rst_n & idex_flush_c;
    assign exmem_write = rst_n & exmem_write_c;
    assign mem_timeout = mem_timeout_q;

endmodule
